// File: rtl/exp_fixed_pkg.sv
// exp_fixed_pkg: shared widths, constants and state type for the exp_fixed slice
package exp_fixed_pkg;
  localparam int QW = 16;
  localparam int QF = 12;
  localparam int IW = 24;
  localparam int IF = 20;
  localparam logic signed [IW-1:0] LN2 = 24'sh0B1721;
  localparam logic [IW-1:0] ONE = 24'h100000;
  localparam logic [QW-1:0] SAT_X = 16'h2146;
  localparam logic [QW-1:0] SAT_Y = 16'h7FFF;
  typedef enum logic [1:0] {IDLE, REDUCE, ITER, SCALE} state_t;
endpackage

// File: rtl/exp_fixed_lut.sv
// exp_fixed_lut: ln(1+2^-i) for i = 1..16 in Q3.20
module exp_fixed_lut
  import exp_fixed_pkg::*;
(
  input  logic [4:0]    idx,
  output logic [IW-1:0] lval
);
  always_comb begin
    lval = '0;
    case (idx)
      5'd1:  lval = 24'h067CC9;
      5'd2:  lval = 24'h0391FF;
      5'd3:  lval = 24'h01E270;
      5'd4:  lval = 24'h00F852;
      5'd5:  lval = 24'h007E0A;
      5'd6:  lval = 24'h003F81;
      5'd7:  lval = 24'h001FE0;
      5'd8:  lval = 24'h000FF8;
      5'd9:  lval = 24'h0007FE;
      5'd10: lval = 24'h000400;
      5'd11: lval = 24'h000200;
      5'd12: lval = 24'h000100;
      5'd13: lval = 24'h000080;
      5'd14: lval = 24'h000040;
      5'd15: lval = 24'h000020;
      5'd16: lval = 24'h000010;
      default: lval = '0;
    endcase
  end
endmodule

// File: rtl/exp_fixed.sv
// exp_fixed: sequential shift-add e^x in Q3.12; EXP_FIXED_OVF_FLAG_EN adds the ovf port
module exp_fixed
  import exp_fixed_pkg::*;
#(
  parameter int N_ITER = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [QW-1:0] data,
  output logic [QW-1:0] output_data,
  output logic          busy,
  output logic          done
`ifdef EXP_FIXED_OVF_FLAG_EN
  ,
  output logic          ovf
`endif
);
  state_t state;
  logic signed [IW-1:0] r, l_i;
  logic [IW-1:0] y;
  logic signed [4:0] k;
  logic [4:0] i;
  logic sat_in, sat;
  logic [47:0] prod;
  logic [IW:0] y_c;
  logic [5:0] sh;
  logic [63:0] rnd;
  logic [43:0] q;
  logic [QW-1:0] res;

  exp_fixed_lut u_lut (.idx(i), .lval(l_i));

  // first-order y*(1+r) correction absorbs the residual left after the last iteration
  always_comb begin
    prod = {24'b0, y} * {24'b0, r};
    y_c = {1'b0, y} + 25'(prod >> IF);
    sh = 6'($signed({k[4], k}) + 6'sd12);
    rnd = ({39'b0, y_c} << sh) + 64'h80000;
    q = 44'(rnd >> IF);
    sat = sat_in || (q > 44'h7FFF);
    res = sat ? SAT_Y : q[QW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      output_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      r <= '0;
      y <= '0;
      k <= '0;
      i <= '0;
      sat_in <= 1'b0;
`ifdef EXP_FIXED_OVF_FLAG_EN
      ovf <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          r <= {data, 8'h00};
          y <= ONE;
          k <= '0;
          sat_in <= $signed(data) >= $signed(SAT_X);
          busy <= 1'b1;
          state <= REDUCE;
        end
        REDUCE: begin
          if (r[IW-1]) begin
            r <= r + LN2;
            k <= k - 5'sd1;
          end else if (r >= LN2) begin
            r <= r - LN2;
            k <= k + 5'sd1;
          end else begin
            i <= 5'd1;
            state <= ITER;
          end
        end
        ITER: begin
          if (r >= l_i) begin
            r <= r - l_i;
            y <= y + (y >> i);
          end
          i <= i + 5'd1;
          state <= (i == 5'(N_ITER)) ? SCALE : ITER;
        end
        SCALE: begin
          output_data <= res;
`ifdef EXP_FIXED_OVF_FLAG_EN
          ovf <= sat;
`endif
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
